// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle between the baud generator and its UART TX/RX users.
// The user side drives the divisor and strobes; the generator returns ticks and status.
interface uart_baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              sync;
    logic              rx_tick;
    logic              tx_tick;
    logic              load_pend;
    logic              cfg_err;

    modport master (
        output en, div_int, div_frac, div_load, sync,
        input  rx_tick, tx_tick, load_pend, cfg_err
    );

    modport slave (
        input  en, div_int, div_frac, div_load, sync,
        output rx_tick, tx_tick, load_pend, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// UART baud tick generator with a fractional, runtime-programmable divisor.
// New divisors go to a shadow and are committed on a tick boundary (or at once when idle).
module uart_baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int DEF_DIV_INT  = 81,
    parameter int DEF_DIV_FRAC = 6
) (
    input  logic                clk,
    input  logic                reset,
    uart_baud_gen_frac_if.slave bus
);
    localparam int                OVS_W    = $clog2(OVS);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV_FRAC);
    localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  active_int;
    logic [DIV_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] active_frac;
    logic [FRAC_W-1:0] shadow_frac;
    logic [OVS_W-1:0]  ovs_cnt;
    logic              load_pend;

    logic              cfg_err;
    logic              running;
    logic              rx_tick;
    logic              tx_tick;
    logic              commit;
    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W-1:0]  reload;

    // Ticks are decoded from registered state so they line up with the cycle cnt reaches 0.
    always_comb begin
        cfg_err  = (active_int < DIV_W'(2));
        running  = bus.en && !cfg_err && !reset;
        rx_tick  = running && !bus.sync && (cnt == '0);
        tx_tick  = rx_tick && (ovs_cnt == OVS_LAST);
        commit   = load_pend && !bus.div_load && (!bus.en || cfg_err || rx_tick);
        frac_sum = {1'b0, acc} + {1'b0, active_frac};
        reload   = active_int - DIV_W'(1) + DIV_W'(frac_sum[FRAC_W]);
    end

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // pre-edge values of cnt/acc/ovs_cnt, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= DEF_INT - DIV_W'(1);
            acc         <= '0;
            ovs_cnt     <= '0;
            active_int  <= DEF_INT;
            active_frac <= DEF_FRAC;
            shadow_int  <= DEF_INT;
            shadow_frac <= DEF_FRAC;
            load_pend   <= 1'b0;
        end else begin
            if (bus.div_load) begin
                shadow_int  <= bus.div_int;
                shadow_frac <= bus.div_frac;
                load_pend   <= 1'b1;
            end else if (commit) begin
                load_pend   <= 1'b0;
            end

            // A commit restarts the phase from the new divisor, so it outranks sync.
            if (commit) begin
                active_int  <= shadow_int;
                active_frac <= shadow_frac;
                acc         <= '0;
                cnt         <= shadow_int - DIV_W'(1);
            end else if (bus.sync) begin
                acc         <= '0;
                cnt         <= active_int - DIV_W'(1);
            end else if (rx_tick) begin
                acc         <= frac_sum[FRAC_W-1:0];
                cnt         <= reload;
            end else if (running) begin
                cnt         <= cnt - DIV_W'(1);
            end

            if (bus.sync) begin
                ovs_cnt <= '0;
            end else if (rx_tick) begin
                ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
            end
        end
    end

    assign bus.rx_tick   = rx_tick;
    assign bus.tx_tick   = tx_tick;
    assign bus.load_pend = load_pend;
    assign bus.cfg_err   = cfg_err;
endmodule
